// File: rtl/uart_pkg.sv
// Shared baud divisor type, helper and reset-default divisor for the UART tick generator.
// BAUD_FRAC_DIV_EN adds a fractional field to the divisor; without it only the integer part exists.
package uart_pkg;

    localparam longint unsigned DEF_CLOCK = 100000000;
    localparam longint unsigned DEF_BAUD  = 9600;
    localparam longint unsigned DEF_OS    = 16;
    localparam int              DEF_DIV_W = 16;

`ifdef BAUD_FRAC_DIV_EN
    localparam int DEF_FRAC_W = 4;

    typedef struct packed {
        logic [DEF_DIV_W-1:0]  div_int;
        logic [DEF_FRAC_W-1:0] div_frac;
    } baud_div_t;
`else
    localparam int DEF_FRAC_W = 0;

    typedef struct packed {
        logic [DEF_DIV_W-1:0] div_int;
    } baud_div_t;
`endif

    // Result is the packed {int, frac} divisor: the low frac_w bits are the fraction.
    function automatic longint unsigned baud_div(input longint unsigned clock,
                                                 input longint unsigned baud,
                                                 input longint unsigned os,
                                                 input int              frac_w);
        return (clock << frac_w) / (baud * os);
    endfunction

    localparam longint unsigned DEF_SCALED = baud_div(DEF_CLOCK, DEF_BAUD, DEF_OS, DEF_FRAC_W);
    localparam baud_div_t DEF_DIV = DEF_SCALED[$bits(baud_div_t)-1:0];
    localparam logic [DEF_DIV_W-1:0] DEF_INT = DEF_DIV.div_int;
`ifdef BAUD_FRAC_DIV_EN
    localparam logic [DEF_FRAC_W-1:0] DEF_FRAC = DEF_DIV.div_frac;
`endif

endpackage

// File: rtl/uart_frac_div.sv
// Rx tick divider: cycle counter with optional fractional carry accumulator (BAUD_FRAC_DIV_EN).
// wrap is the combinational end-of-period decision; tick_rx is its registered pulse.
module uart_frac_div
    import uart_pkg::*;
#(
    parameter int DIV_W = 16
`ifdef BAUD_FRAC_DIV_EN
    , parameter int FRAC_W = 4
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [DIV_W-1:0] div_int,
`ifdef BAUD_FRAC_DIV_EN
    input  logic [FRAC_W-1:0] div_frac,
`endif
    output logic             wrap,
    output logic             tick_rx
);

    logic [DIV_W:0]   count;
    logic [DIV_W:0]   period;
    logic [DIV_W:0]   last;
    logic [DIV_W-1:0] eff_int;

    assign eff_int = (div_int == '0) ? DIV_W'(1) : div_int;

`ifdef BAUD_FRAC_DIV_EN
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   acc_sum;

    assign acc_sum = {1'b0, acc} + {1'b0, div_frac};
    assign period  = {1'b0, eff_int} + {{DIV_W{1'b0}}, acc_sum[FRAC_W]};
`else
    assign period  = {1'b0, eff_int};
`endif

    assign last = period - {{DIV_W{1'b0}}, 1'b1};
    // >= rather than == so a divisor shrinking mid-count cannot strand the counter past the end.
    assign wrap = run && (count >= last);

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            count   <= '0;
            tick_rx <= 1'b0;
`ifdef BAUD_FRAC_DIV_EN
            acc     <= '0;
`endif
        end else if (wrap) begin
            count   <= '0;
            tick_rx <= 1'b1;
`ifdef BAUD_FRAC_DIV_EN
            acc     <= acc_sum[FRAC_W-1:0];
`endif
        end else begin
            count   <= count + {{DIV_W{1'b0}}, 1'b1};
            tick_rx <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_baud_tick_gen.sv
// UART baud tick generator: rx oversample, mid-bit and tx clock-enable ticks from a shadowed divisor.
// Define BAUD_FRAC_DIV_EN to honour div_frac; otherwise the period is max(div_int, 1).
module uart_baud_tick_gen
    import uart_pkg::*;
#(
    parameter int CLOCK      = 100000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16,
    parameter int FRAC_W     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          sync,
    input  logic                          div_wr,
    input  logic [DIV_W-1:0]              div_int,
    input  logic [FRAC_W-1:0]             div_frac,
    output logic                          div_pending,
    output logic                          tick_rx,
    output logic                          tick_mid,
    output logic                          tick_tx,
    output logic [$clog2(OVERSAMPLE)-1:0] os_idx
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2);

`ifdef BAUD_FRAC_DIV_EN
    localparam longint unsigned RST_SCALED =
        baud_div(64'(CLOCK), 64'(BAUD_RATE), 64'(OVERSAMPLE), FRAC_W);
    localparam logic [DIV_W-1:0]  RST_INT  = RST_SCALED[FRAC_W +: DIV_W];
    localparam logic [FRAC_W-1:0] RST_FRAC = RST_SCALED[FRAC_W-1:0];
`else
    localparam longint unsigned RST_SCALED =
        baud_div(64'(CLOCK), 64'(BAUD_RATE), 64'(OVERSAMPLE), 0);
    localparam logic [DIV_W-1:0]  RST_INT  = RST_SCALED[DIV_W-1:0];
`endif

    logic             run;
    logic             apply;
    logic             wrap;
    logic [DIV_W-1:0] act_int;
    logic [DIV_W-1:0] sh_int;
    logic [OS_W-1:0]  os_nxt;

    assign run    = en & ~sync;
    // tick_tx here is the registered pulse, so the swap lands on the cycle after it.
    assign apply  = div_pending & (tick_tx | ~en | sync);
    assign os_nxt = (os_idx == OS_LAST) ? '0 : os_idx + OS_W'(1);

`ifdef BAUD_FRAC_DIV_EN
    logic [FRAC_W-1:0] act_frac;
    logic [FRAC_W-1:0] sh_frac;
`else
    logic unused_frac;
    assign unused_frac = ^div_frac;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            act_int     <= RST_INT;
            sh_int      <= RST_INT;
            div_pending <= 1'b0;
`ifdef BAUD_FRAC_DIV_EN
            act_frac    <= RST_FRAC;
            sh_frac     <= RST_FRAC;
`endif
        end else if (div_wr) begin
            // A write in the same cycle as an apply keeps the newest value pending.
            sh_int      <= div_int;
            div_pending <= 1'b1;
`ifdef BAUD_FRAC_DIV_EN
            sh_frac     <= div_frac;
`endif
        end else if (apply) begin
            act_int     <= sh_int;
            div_pending <= 1'b0;
`ifdef BAUD_FRAC_DIV_EN
            act_frac    <= sh_frac;
`endif
        end
    end

    uart_frac_div #(
        .DIV_W   (DIV_W)
`ifdef BAUD_FRAC_DIV_EN
        , .FRAC_W(FRAC_W)
`endif
    ) u_frac_div (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .div_int (act_int),
`ifdef BAUD_FRAC_DIV_EN
        .div_frac(act_frac),
`endif
        .wrap    (wrap),
        .tick_rx (tick_rx)
    );

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            os_idx   <= '0;
            tick_mid <= 1'b0;
            tick_tx  <= 1'b0;
        end else if (wrap) begin
            os_idx   <= os_nxt;
            tick_mid <= (os_nxt == OS_MID);
            tick_tx  <= (os_nxt == OS_LAST);
        end else begin
            tick_mid <= 1'b0;
            tick_tx  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_baud_tick_gen.sv
// Directed bench for uart_baud_tick_gen: expected tick gaps/indices queued at stimulus, checked on each tick.
`timescale 1ns/1ps
module tb_uart_baud_tick_gen;

    localparam int CLOCK      = 1600;
    localparam int BAUD_RATE  = 10;
    localparam int OVERSAMPLE = 16;
    localparam int DIV_W      = 16;
    localparam int FRAC_W     = 4;
    localparam int OS_W       = $clog2(OVERSAMPLE);
    localparam int EXP_DEF_INT  = 10;
    localparam int EXP_DEF_FRAC = 0;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              sync;
    logic              div_wr;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              div_pending;
    logic              tick_rx;
    logic              tick_mid;
    logic              tick_tx;
    logic [OS_W-1:0]   os_idx;

    always #5 clk = ~clk;

    uart_baud_tick_gen #(
        .CLOCK     (CLOCK),
        .BAUD_RATE (BAUD_RATE),
        .OVERSAMPLE(OVERSAMPLE),
        .DIV_W     (DIV_W),
        .FRAC_W    (FRAC_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .sync       (sync),
        .div_wr     (div_wr),
        .div_int    (div_int),
        .div_frac   (div_frac),
        .div_pending(div_pending),
        .tick_rx    (tick_rx),
        .tick_mid   (tick_mid),
        .tick_tx    (tick_tx),
        .os_idx     (os_idx)
    );

    int checks = 0;
    int errors = 0;
    int lead = 0;
    int cyc = 0;
    int tx_prev = -1;
    int tx_period = 0;
    int t0;
    int exp_gap[$];
    int exp_os[$];

    int m_int, m_frac, m_acc, m_os, m_sh_int, m_sh_frac;
    bit m_pend;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5ms;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc1();
        @(negedge clk);
        lead++;
    endtask

    task automatic model_reset();
        m_int = EXP_DEF_INT; m_frac = EXP_DEF_FRAC;
        m_sh_int = EXP_DEF_INT; m_sh_frac = EXP_DEF_FRAC;
        m_acc = 0; m_os = 0; m_pend = 0;
    endtask

    task automatic model_apply();
        if (m_pend) begin
            m_int = m_sh_int; m_frac = m_sh_frac; m_pend = 0;
        end
    endtask

    task automatic model_clear();
        m_acc = 0; m_os = 0;
        model_apply();
    endtask

    task automatic model_tick(output int gap, output int os);
        int eff;
        int sum;
        eff = (m_int == 0) ? 1 : m_int;
`ifdef BAUD_FRAC_DIV_EN
        sum = m_acc + m_frac;
        gap = eff + sum / (1 << FRAC_W);
        m_acc = sum % (1 << FRAC_W);
`else
        sum = 0;
        gap = eff + sum;
`endif
        m_os = (m_os + 1) % OVERSAMPLE;
        os = m_os;
        if (m_os == OVERSAMPLE - 1) model_apply();
    endtask

    task automatic push_exp(input int n);
        int g, o;
        for (int i = 0; i < n; i++) begin
            model_tick(g, o);
            exp_gap.push_back(g);
            exp_os.push_back(o);
        end
    endtask

    task automatic consume(input int n, input string tag);
        int gap, eg, eo;
        for (int i = 0; i < n; i++) begin
            gap = lead;
            lead = 0;
            do begin
                @(negedge clk);
                gap++;
            end while (tick_rx !== 1'b1 && gap < 1000);
            if (exp_gap.size() == 0) begin
                errors++;
                $error("FAIL %s scoreboard empty", tag);
                return;
            end
            eg = exp_gap.pop_front();
            eo = exp_os.pop_front();
            check({tag, "_gap"}, gap, eg);
            check({tag, "_os"}, int'(os_idx), eo);
            check({tag, "_mid"}, int'(tick_mid), int'(eo == OVERSAMPLE / 2));
            check({tag, "_tx"}, int'(tick_tx), int'(eo == OVERSAMPLE - 1));
            if (tick_tx === 1'b1) begin
                if (tx_period > 0 && tx_prev >= 0)
                    check({tag, "_tx_period"}, cyc - tx_prev, tx_period);
                tx_prev = cyc;
            end
        end
    endtask

    task automatic write_div(input int i, input int f);
        div_int  = DIV_W'(i);
        div_frac = FRAC_W'(f);
        div_wr   = 1'b1;
        cyc1();
        div_wr   = 1'b0;
        m_sh_int = i; m_sh_frac = f; m_pend = 1;
    endtask

    task automatic en_pulse(input int n, input string tag);
        int seen;
        seen = 0;
        en = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (tick_rx === 1'b1 || tick_mid === 1'b1 || tick_tx === 1'b1) seen++;
        end
        check({tag, "_ticks_low"}, seen, 0);
        check({tag, "_os_low"}, int'(os_idx), 0);
        en = 1'b1;
        lead = 0;
        model_clear();
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; sync = 1'b0; div_wr = 1'b0;
        div_int = '0; div_frac = '0;
        repeat (3) @(negedge clk);
        check("rst_tick_rx", int'(tick_rx), 0);
        check("rst_tick_mid", int'(tick_mid), 0);
        check("rst_tick_tx", int'(tick_tx), 0);
        check("rst_os_idx", int'(os_idx), 0);
        check("rst_pending", int'(div_pending), 0);

        // default divisor straight out of reset
        rst = 1'b0; lead = 0; model_reset();
        tx_prev = -1; tx_period = 160;
        push_exp(32);
        consume(32, "p1");
        tx_period = 0;

        // fractional divisor 3 + 8/16
        write_div(3, 8);
        check("p2_pend_set", int'(div_pending), 1);
        en_pulse(1, "p2_apply");
        check("p2_pend_clr", int'(div_pending), 0);
        t0 = cyc;
        push_exp(16);
        consume(16, "p2");
`ifdef BAUD_FRAC_DIV_EN
        check("p2_window", cyc - t0, 56);
`else
        check("p2_window", cyc - t0, 48);
`endif

        // mid-bit divisor update held until tick_tx
        push_exp(3);
        consume(3, "p3a");
        check("p3_os3", int'(os_idx), 3);
        write_div(5, 0);
        check("p3_pend_set", int'(div_pending), 1);
        push_exp(13);
        consume(12, "p3b");
        check("p3_pend_at_tx", int'(div_pending), 1);
        cyc1();
        check("p3_pend_clr", int'(div_pending), 0);
        consume(1, "p3c");
        push_exp(3);
        consume(3, "p3d");

        // sync lands exactly on a due tick
        repeat (4) @(negedge clk);
        sync = 1'b1;
        @(negedge clk);
        check("p4_no_tick", int'(tick_rx), 0);
        check("p4_os0", int'(os_idx), 0);
        sync = 1'b0;
        lead = 0;
        model_clear();
        push_exp(4);
        consume(4, "p4");

        // en low for 7 cycles
        en_pulse(7, "p5");
        push_exp(3);
        consume(3, "p5");

        // div_int = 0 clamps to 1; second write overwrites the first
        write_div(9, 0);
        write_div(0, 0);
        check("p6_pend_set", int'(div_pending), 1);
        en_pulse(1, "p6_apply");
        tx_prev = -1; tx_period = 16;
        push_exp(32);
        consume(32, "p6");
        tx_period = 0;

        // reset with a divisor pending
        write_div(7, 0);
        check("p6_pend_before_rst", int'(div_pending), 1);
        rst = 1'b1;
        @(negedge clk);
        check("p6_rst_pend", int'(div_pending), 0);
        check("p6_rst_os", int'(os_idx), 0);
        check("p6_rst_tick", int'(tick_rx), 0);
        rst = 1'b0;
        lead = 0;
        model_reset();
        push_exp(2);
        consume(2, "p6_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
